// File: rtl/riscv_core_axi_pkg.sv
// Shared AXI4 read-side constants and the refill FSM state type for the
// data-cache AXI adapters.
package riscv_core_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Byte-offset bits inside one 256-bit (32-byte) cache line.
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } axi_rd_state_e;

endpackage

// File: rtl/riscv_core_dcache_axi_read_adapter.sv
// Data-cache refill adapter: turns one line-refill request into a single
// AXI4 INCR read burst and assembles the R beats into a full cache line.
module riscv_core_dcache_axi_read_adapter
  import riscv_core_axi_pkg::*;
#(
  parameter  int ADDR_WIDTH    = 32,
  parameter  int AXI_BUS_WIDTH = 32,
  parameter  int LINE_WIDTH    = 256,
  localparam int BEATS         = LINE_WIDTH / AXI_BUS_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]    i_mem_read_address,
  output logic                     o_mem_read_done,
  output logic [LINE_WIDTH-1:0]    o_block_from_axi,
  output logic                     o_read_error,
  output logic                     o_arvalid,
  input  logic                     i_arready,
  output logic [ADDR_WIDTH-1:0]    o_araddr,
  output logic [7:0]               o_arlen,
  output logic [2:0]               o_arsize,
  output logic [1:0]               o_arburst,
  input  logic                     i_rvalid,
  output logic                     o_rready,
  input  logic [AXI_BUS_WIDTH-1:0] i_rdata,
  input  logic [1:0]               i_rresp,
  input  logic                     i_rlast
);

  // Counter must be able to hold BEATS itself (saturation value).
  localparam int                CNT_W   = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0]  BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(BEATS - 1);

  axi_rd_state_e    state;
  logic [CNT_W-1:0] beat_cnt;
  logic             err_q;
  logic             armed;
  logic             resp_bad;
  logic             len_bad;

  // Line-offset bits of the miss address never reach ARADDR.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^i_mem_read_address[LINE_OFFSET_BITS-1:0];

  // Burst shape is fixed: one full line of bus-width beats, incrementing.
  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'($clog2(AXI_BUS_WIDTH / 8));
  assign o_arburst = AXI_BURST_INCR;

  assign resp_bad = (i_rresp != AXI_RESP_OKAY);
  // rlast must coincide with the last slot; early or late both count as faults.
  assign len_bad  = i_rlast && (beat_cnt != LAST_C);

  // Refill FSM: AR issue, beat collection, one-cycle done/error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= IDLE;
      o_arvalid        <= 1'b0;
      o_rready         <= 1'b0;
      o_mem_read_done  <= 1'b0;
      o_read_error     <= 1'b0;
      o_araddr         <= '0;
      o_block_from_axi <= '0;
      beat_cnt         <= '0;
      err_q            <= 1'b0;
      armed            <= 1'b1;
    end else begin
      o_mem_read_done <= 1'b0;
      o_read_error    <= 1'b0;
      case (state)
        IDLE: begin
          // Re-arm only once the controller has visibly dropped its request.
          if (!i_mem_read_req) begin
            armed <= 1'b1;
          end else if (armed) begin
            o_araddr  <= {i_mem_read_address[ADDR_WIDTH-1:LINE_OFFSET_BITS],
                          LINE_OFFSET_BITS'(0)};
            beat_cnt  <= '0;
            err_q     <= 1'b0;
            o_arvalid <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (i_arready) begin
            o_arvalid <= 1'b0;
            o_rready  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          // rready is held high for the whole of DATA, so rvalid is the handshake.
          if (i_rvalid) begin
            if (beat_cnt < BEATS_C)
              o_block_from_axi[int'(beat_cnt)*AXI_BUS_WIDTH +: AXI_BUS_WIDTH] <= i_rdata;
            if (beat_cnt != BEATS_C)
              beat_cnt <= beat_cnt + 1'b1;
            err_q <= err_q | resp_bad | len_bad;
            if (i_rlast) begin
              o_rready        <= 1'b0;
              o_mem_read_done <= 1'b1;
              o_read_error    <= err_q | resp_bad | len_bad;
              state           <= DONE;
            end
          end
        end
        DONE: begin
          armed <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
